proc_scan_ctrl: RTL and testbench

Sequencer that runs the image-processing pass over the captured frame buffer. On a rising edge of `init_procesamiento` it waits for the capture path to finish the current frame. It then freezes capture, takes the buffer read port from the VGA path, and scans all 160x120 RGB444 pixels. Finally it publishes the dominant `color` and a coarse `figure` class with `done`. It sits between the camera capture/frame-buffer block and the memory-mapped processing registers in `test_cam`.

---
 rtl/proc_scan_if.sv | 32 +++
 rtl/proc_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_proc_scan_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/proc_scan_if.sv
// proc_scan_if: handshake and frame-buffer bus between proc_scan_ctrl and its surroundings.
// Ports (master = proc_scan_ctrl):
//   init_procesamiento  in  start request, acts on rising edge
//   cam_frame_done      in  one-cycle pulse at the last capture write of a frame
//   mem_data[11:0]      in  pixel {R,G,B} returned one cycle after mem_addr
//   capture_hold        out freeze frame-buffer writes
//   proc_owns_mem       out buffer read mux selects mem_addr, VGA blanked
//   mem_addr[AW-1:0]    out buffer read address
//   color[1:0]          out 00 none, 01 red, 10 green, 11 blue
//   figure[1:0]         out 00 none, 01 triangle, 10 square, 11 circle
//   done                out result valid level
interface proc_scan_if #(
  parameter int AW = 15
);
  logic          init_procesamiento;
  logic          cam_frame_done;
  logic [11:0]   mem_data;
  logic          capture_hold;
  logic          proc_owns_mem;
  logic [AW-1:0] mem_addr;
  logic [1:0]    color;
  logic [1:0]    figure;
  logic          done;
  modport master (
    input  init_procesamiento, cam_frame_done, mem_data,
    output capture_hold, proc_owns_mem, mem_addr, color, figure, done
  );
  modport slave (
    output init_procesamiento, cam_frame_done, mem_data,
    input  capture_hold, proc_owns_mem, mem_addr, color, figure, done
  );
endinterface

// File: rtl/proc_scan_ctrl.sv
// proc_scan_ctrl: scans the captured HxV RGB444 frame and classifies dominant color and coarse figure.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   bus    proc_scan_if.master: init/frame-done requests, buffer read port, color/figure/done result
module proc_scan_ctrl #(
  parameter int H       = 160,
  parameter int V       = 120,
  parameter int AW      = 15,
  parameter int MIN_PIX = 16
) (
  input logic         clk,
  input logic         rst_n,
  proc_scan_if.master bus
);
  localparam int XW = $clog2(H);
  localparam int YW = $clog2(V);
  localparam logic [AW-1:0] A_LAST = AW'(H * V - 1);
  localparam logic [XW-1:0] X_LAST = XW'(H - 1);
  localparam logic [YW-1:0] Y_MID  = YW'(V / 3);
  localparam logic [YW-1:0] Y_BOT  = YW'(V - V / 3);
  localparam logic [17:0]   MIN18  = 18'(MIN_PIX);
  typedef enum logic [2:0] {IDLE, WAIT_FRAME, SCAN, DRAIN, DECIDE, DONE} state_t;
  state_t        state_q, state_d;
  logic          init_prev_q;
  logic [AW-1:0] addr_q, addr_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [YW-1:0] py_q, py_d;
  logic          acc_v_q, acc_v_d;
  logic [14:0]   cnt_r_q, cnt_r_d, cnt_g_q, cnt_g_d, cnt_b_q, cnt_b_d;
  logic [14:0]   cnt_top_q, cnt_top_d, cnt_mid_q, cnt_mid_d, cnt_bot_q, cnt_bot_d;
  logic [1:0]    color_q, color_d, figure_q, figure_d;
  logic          init_rise, start, last_addr;
  logic [3:0]    pr, pg, pb;
  logic          dom_r, dom_g, dom_b, acc;
  logic          in_top, in_bot;
  logic          r_win, g_win;
  logic [14:0]   win_cnt;
  logic [17:0]   t18, m18, b18, sum18;
  logic [1:0]    col, fig;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      init_prev_q <= 1'b0;
      addr_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      py_q        <= '0;
      acc_v_q     <= 1'b0;
      cnt_r_q     <= '0;
      cnt_g_q     <= '0;
      cnt_b_q     <= '0;
      cnt_top_q   <= '0;
      cnt_mid_q   <= '0;
      cnt_bot_q   <= '0;
      color_q     <= 2'b00;
      figure_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      init_prev_q <= bus.init_procesamiento;
      addr_q      <= addr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      py_q        <= py_d;
      acc_v_q     <= acc_v_d;
      cnt_r_q     <= cnt_r_d;
      cnt_g_q     <= cnt_g_d;
      cnt_b_q     <= cnt_b_d;
      cnt_top_q   <= cnt_top_d;
      cnt_mid_q   <= cnt_mid_d;
      cnt_bot_q   <= cnt_bot_d;
      color_q     <= color_d;
      figure_q    <= figure_d;
    end
  always_comb begin
    init_rise = bus.init_procesamiento && !init_prev_q;
    last_addr = addr_q == A_LAST;
    state_d   = state_q;
    case (state_q)
      IDLE, DONE: state_d = init_rise ? WAIT_FRAME : state_q;
      WAIT_FRAME: state_d = bus.cam_frame_done ? SCAN : state_q;
      SCAN:       state_d = last_addr ? DRAIN : state_q;
      DRAIN:      state_d = DECIDE;
      DECIDE:     state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end
  // Address and x/y generation; the x/y of each issued address is delayed one
  // cycle (py_q, acc_v_q) so it lines up with the returned mem_data.
  always_comb begin
    start   = (state_q == IDLE || state_q == DONE) && init_rise;
    addr_d  = start ? '0 : (state_q == SCAN && !last_addr) ? addr_q + 1'b1 : addr_q;
    x_d     = start ? '0 : (state_q == SCAN) ? ((x_q == X_LAST) ? '0 : x_q + 1'b1) : x_q;
    y_d     = start ? '0 : (state_q == SCAN && x_q == X_LAST) ? y_q + 1'b1 : y_q;
    py_d    = y_q;
    acc_v_d = state_q == SCAN;
  end
  // A channel dominates when its nibble is >= 8 and the other two are < 8.
  always_comb begin
    pr        = bus.mem_data[11:8];
    pg        = bus.mem_data[7:4];
    pb        = bus.mem_data[3:0];
    dom_r     = pr[3] && !pg[3] && !pb[3];
    dom_g     = pg[3] && !pr[3] && !pb[3];
    dom_b     = pb[3] && !pr[3] && !pg[3];
    acc       = acc_v_q && (dom_r || dom_g || dom_b);
    in_top    = py_q < Y_MID;
    in_bot    = py_q >= Y_BOT;
    cnt_r_d   = start ? '0 : cnt_r_q + {14'b0, acc_v_q && dom_r};
    cnt_g_d   = start ? '0 : cnt_g_q + {14'b0, acc_v_q && dom_g};
    cnt_b_d   = start ? '0 : cnt_b_q + {14'b0, acc_v_q && dom_b};
    cnt_top_d = start ? '0 : cnt_top_q + {14'b0, acc && in_top};
    cnt_mid_d = start ? '0 : cnt_mid_q + {14'b0, acc && !in_top && !in_bot};
    cnt_bot_d = start ? '0 : cnt_bot_q + {14'b0, acc && in_bot};
  end
  // Decision: ties resolve red > green > blue; figure compares row-band
  // populations in 18 bits so 8*T and 7*M cannot overflow.
  always_comb begin
    r_win    = cnt_r_q >= cnt_g_q && cnt_r_q >= cnt_b_q;
    g_win    = !r_win && cnt_g_q >= cnt_b_q;
    win_cnt  = r_win ? cnt_r_q : g_win ? cnt_g_q : cnt_b_q;
    col      = ({3'b0, win_cnt} < MIN18) ? 2'b00 : r_win ? 2'b01 : g_win ? 2'b10 : 2'b11;
    t18      = {3'b0, cnt_top_q};
    m18      = {3'b0, cnt_mid_q};
    b18      = {3'b0, cnt_bot_q};
    sum18    = t18 + m18 + b18;
    fig      = (sum18 < MIN18)             ? 2'b00 :
               (b18 >= (t18 << 1))         ? 2'b01 :
               ((t18 << 3) >= 18'd7 * m18) ? 2'b10 : 2'b11;
    color_d  = (state_q == DECIDE) ? col : color_q;
    figure_d = (state_q == DECIDE) ? fig : figure_q;
  end
  always_comb begin
    bus.capture_hold  = state_q inside {SCAN, DRAIN, DECIDE, DONE};
    bus.proc_owns_mem = state_q inside {SCAN, DRAIN};
    bus.done          = state_q == DONE;
    bus.mem_addr      = addr_q;
    bus.color         = color_q;
    bus.figure        = figure_q;
  end
endmodule

// File: tb/tb_proc_scan_ctrl.sv
// tb_proc_scan_ctrl: full-size and reduced-size proc_scan_ctrl checked against a frame model and scoreboard.
module tb_proc_scan_ctrl;
  typedef struct {int pat; logic [1:0] color; logic [1:0] figure;} vec_t;
  typedef struct {int color; int figure; int lat;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  proc_scan_if #(.AW(7))  si ();
  proc_scan_if #(.AW(15)) bi ();
  proc_scan_ctrl #(.H(12), .V(9), .AW(7), .MIN_PIX(16)) dut_s (.clk(clk), .rst_n(rst_n), .bus(si.master));
  proc_scan_ctrl #(.H(160), .V(120), .AW(15), .MIN_PIX(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bi.master));
  logic [11:0] mem_s [108];
  logic [11:0] mem_b [19200];
  always @(posedge clk) begin
    si.mem_data <= (int'(si.mem_addr) < 108) ? mem_s[int'(si.mem_addr)] : 12'h000;
    bi.mem_data <= (int'(bi.mem_addr) < 19200) ? mem_b[int'(bi.mem_addr)] : 12'h000;
  end
  int n_cmp = 0, n_bad = 0;
  int a_cnt [2], a_bad [2], own_cnt [2], lc [2], lf [2];
  logic own_p [2];
  exp_t sb [$];
  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic mon(int s, logic own, int addr, int n);
    if (own && !own_p[s]) begin
      a_cnt[s] = 0; a_bad[s] = 0; own_cnt[s] = 0;
    end
    if (own) begin
      own_cnt[s]++;
      if (a_cnt[s] < n) begin
        if (addr != a_cnt[s]) a_bad[s]++;
        a_cnt[s]++;
      end
    end
    own_p[s] = own;
  endtask
  always @(negedge clk) begin
    mon(0, si.proc_owns_mem, int'(si.mem_addr), 108);
    mon(1, bi.proc_owns_mem, int'(bi.mem_addr), 19200);
  end
  function automatic logic [11:0] pix(int pat, int x, int y, int a, int h, int v);
    case (pat)
      0:  return 12'h00F;
      1:  return 12'h000;
      2:  return (y >= v - v / 3) ? 12'hF00 : 12'h000;
      3:  return (x < h / 2) ? 12'hF00 : 12'h0F0;
      4:  return (x < h / 2) ? 12'h0F0 : 12'h00F;
      5:  return 12'hFFF;
      6:  return 12'h877;
      7:  return 12'h788;
      8:  return (a < 15) ? 12'hF00 : 12'h000;
      9:  return (a < 16) ? 12'hF00 : 12'h000;
      10: return (y >= 2 && y <= 6) ? 12'h00F : 12'h000;
      11: return (y < v / 3) ? 12'hF00 : 12'h000;
      12: return (y == 0 || y == 6 || y == 7) ? 12'h00C : 12'h000;
      13: return (a < 21 || (a >= 36 && a < 60)) ? 12'h0A0 : 12'h000;
      14: return (a < 20 || (a >= 36 && a < 60)) ? 12'h0A0 : 12'h000;
      default: return 12'h000;
    endcase
  endfunction
  function automatic logic [6:0] st(int s);
    return s ? {bi.capture_hold, bi.proc_owns_mem, bi.done, bi.color, bi.figure}
             : {si.capture_hold, si.proc_owns_mem, si.done, si.color, si.figure};
  endfunction
  task automatic set_init(int s, logic v);
    if (s != 0) bi.init_procesamiento = v; else si.init_procesamiento = v;
  endtask
  task automatic set_fd(int s, logic v);
    if (s != 0) bi.cam_frame_done = v; else si.cam_frame_done = v;
  endtask
  task automatic fill(int s, int pat);
    int h = (s != 0) ? 160 : 12;
    int v = (s != 0) ? 120 : 9;
    for (int a = 0; a < h * v; a++)
      if (s != 0) mem_b[a] = pix(pat, a % h, a / h, a, h, v);
      else        mem_s[a] = pix(pat, a % h, a / h, a, h, v);
  endtask
  task automatic run_frame(int s, int pat, int ec, int ef, bit disturb);
    int n = (s != 0) ? 19200 : 108;
    int lat;
    logic [6:0] o;
    exp_t g;
    fill(s, pat);
    @(negedge clk) set_init(s, 1'b0);
    @(negedge clk) set_init(s, 1'b1);
    @(negedge clk);
    o = st(s);
    chk($sformatf("p%0d_wait_done_low", pat), int'(o[4]), 0);
    chk($sformatf("p%0d_wait_hold_low", pat), int'(o[6]), 0);
    chk($sformatf("p%0d_wait_color_kept", pat), int'(o[3:2]), lc[s]);
    chk($sformatf("p%0d_wait_figure_kept", pat), int'(o[1:0]), lf[s]);
    set_fd(s, 1'b1);
    @(negedge clk) set_fd(s, 1'b0);
    sb.push_back('{ec, ef, n + 3});
    lat = 1;
    o = st(s);
    while (!o[4] && lat < n + 100) begin
      if (disturb) begin
        if (lat == 200 || lat == 5000) set_init(s, 1'b0);
        if (lat == 201 || lat == 5001) set_init(s, 1'b1);
        if (lat == 300) set_fd(s, 1'b1);
        if (lat == 301) set_fd(s, 1'b0);
      end
      @(negedge clk);
      lat++;
      o = st(s);
    end
    g = sb.pop_front();
    chk($sformatf("p%0d_latency", pat), lat, g.lat);
    chk($sformatf("p%0d_color", pat), int'(o[3:2]), g.color);
    chk($sformatf("p%0d_figure", pat), int'(o[1:0]), g.figure);
    chk($sformatf("p%0d_done_hold", pat), int'({o[6], o[5]}), 2);
    chk($sformatf("p%0d_addr_seq_errors", pat), a_bad[s], 0);
    chk($sformatf("p%0d_addr_count", pat), a_cnt[s], n);
    chk($sformatf("p%0d_own_cycles", pat), own_cnt[s], n + 1);
    lc[s] = ec;
    lf[s] = ef;
  endtask
  initial begin
    vec_t tbl [15];
    logic [6:0] o;
    int k;
    tbl = '{'{0, 2'd3, 2'd2}, '{1, 2'd0, 2'd0}, '{2, 2'd1, 2'd1}, '{3, 2'd1, 2'd2},
            '{4, 2'd2, 2'd2}, '{5, 2'd0, 2'd0}, '{6, 2'd1, 2'd2}, '{7, 2'd0, 2'd0},
            '{8, 2'd0, 2'd0}, '{9, 2'd1, 2'd2}, '{10, 2'd3, 2'd3}, '{11, 2'd1, 2'd2},
            '{12, 2'd3, 2'd1}, '{13, 2'd2, 2'd2}, '{14, 2'd2, 2'd3}};
    for (int s = 0; s < 2; s++) begin
      lc[s] = 0; lf[s] = 0; own_p[s] = 1'b0; a_cnt[s] = 0; a_bad[s] = 0; own_cnt[s] = 0;
    end
    si.init_procesamiento = 1'b0; si.cam_frame_done = 1'b0;
    bi.init_procesamiento = 1'b0; bi.cam_frame_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs_small", int'(st(0)), 0);
    chk("rst_outputs_big", int'(st(1)), 0);
    chk("rst_addr_big", int'(bi.mem_addr), 0);
    rst_n = 1'b1;
    fill(0, 0);
    @(negedge clk);
    si.init_procesamiento = 1'b1;
    si.cam_frame_done = 1'b1;
    @(negedge clk) si.cam_frame_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("same_cycle_fd_ignored_own", int'(si.proc_owns_mem), 0);
    chk("same_cycle_fd_ignored_hold", int'(si.capture_hold), 0);
    si.cam_frame_done = 1'b1;
    @(negedge clk) si.cam_frame_done = 1'b0;
    k = 0;
    while (!si.done && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("late_fd_latency", k + 1, 111);
    chk("late_fd_color", int'(si.color), 3);
    lc[0] = 3; lf[0] = 2;
    for (int i = 0; i < 15; i++) run_frame(0, tbl[i].pat, int'(tbl[i].color), int'(tbl[i].figure), 1'b0);
    run_frame(0, 1, 0, 0, 1'b0);
    repeat (20) @(negedge clk);
    o = st(0);
    chk("black_hold_capture", int'(o[6]), 1);
    chk("black_hold_done", int'(o[4]), 1);
    chk("black_hold_own", int'(o[5]), 0);
    run_frame(1, 0, 3, 2, 1'b1);
    fill(1, 0);
    @(negedge clk) bi.init_procesamiento = 1'b0;
    @(negedge clk) bi.init_procesamiento = 1'b1;
    @(negedge clk) bi.cam_frame_done = 1'b1;
    @(negedge clk) bi.cam_frame_done = 1'b0;
    k = 0;
    while (int'(bi.mem_addr) != 5000 && k < 6000) begin
      @(negedge clk);
      k++;
    end
    chk("reach_addr_5000", int'(bi.mem_addr), 5000);
    rst_n = 1'b0;
    #1;
    chk("midscan_rst_outputs", int'(st(1)), 0);
    chk("midscan_rst_addr", int'(bi.mem_addr), 0);
    bi.init_procesamiento = 1'b0;
    si.init_procesamiento = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    lc[1] = 0; lf[1] = 0;
    run_frame(1, 2, 1, 1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
